// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: arbitrates instruction-fetch and data requests and
// steps MAR/MDR/RAM/IR strobes through one RAM access with an MFC timeout.
module mem_access_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       RESET,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_write,
    input  logic [1:0] data_size,
    input  logic       data_signed,
    input  logic       MFC,
    output logic       MAR_Enable,
    output logic       MDR_Enable,
    output logic       MDR_Mux_select,
    output logic       RAM_enable,
    output logic [5:0] RAM_OpCode,
    output logic       IR_Enable,
    output logic       fetch_done,
    output logic       data_done,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        WAIT_MFC,
        CAPTURE,
        ERROR
    } state_t;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          last_data;
    logic          req_fetch;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic          grant_data;
    logic [5:0]    op_latched;

    // On a tie the type not granted last wins; a lone request always wins.
    assign grant_data = data_req && (!fetch_req || !last_data);
    assign op_latched = req_fetch ? 6'b000010 : {2'b00, req_signed, req_write, req_size};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_data  <= 1'b0;
            req_fetch  <= 1'b0;
            req_write  <= 1'b0;
            req_size   <= 2'b00;
            req_signed <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (fetch_req || data_req)) begin
                last_data  <= grant_data;
                req_fetch  <= !grant_data;
                req_write  <= data_write;
                req_size   <= data_size;
                req_signed <= data_signed;
            end
            if (state == LOAD_MAR) begin
                wait_cnt <= '0;
            end else if (state == WAIT_MFC && !MFC) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (fetch_req || data_req) state_nxt = LOAD_MAR;
            LOAD_MAR: state_nxt = WAIT_MFC;
            WAIT_MFC: begin
                if (MFC)                        state_nxt = CAPTURE;
                else if (wait_cnt == CNT_LAST)  state_nxt = ERROR;
            end
            CAPTURE:  state_nxt = IDLE;
            ERROR:    state_nxt = ERROR;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MAR_Enable     = 1'b0;
        MDR_Enable     = 1'b0;
        MDR_Mux_select = 1'b0;
        RAM_enable     = 1'b0;
        RAM_OpCode     = 6'b000000;
        IR_Enable      = 1'b0;
        fetch_done     = 1'b0;
        data_done      = 1'b0;
        busy           = (state != IDLE);
        timeout_err    = 1'b0;
        unique case (state)
            LOAD_MAR: begin
                MAR_Enable = 1'b1;
                // Store data enters MDR from the datapath alongside the address.
                if (!req_fetch && req_write) MDR_Enable = 1'b1;
            end
            WAIT_MFC: begin
                RAM_enable = 1'b1;
                RAM_OpCode = op_latched;
            end
            CAPTURE: begin
                if (req_fetch) begin
                    IR_Enable  = 1'b1;
                    fetch_done = 1'b1;
                end else begin
                    data_done = 1'b1;
                    if (!req_write) begin
                        MDR_Enable     = 1'b1;
                        MDR_Mux_select = 1'b1;
                    end
                end
            end
            ERROR:   timeout_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: a timeline model of each access checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_access_sequencer;

    localparam int TIMEOUT = 16;

    logic       Clk = 1'b0;
    logic       RESET, fetch_req, data_req, data_write, data_signed, MFC;
    logic [1:0] data_size;
    logic       MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       IR_Enable, fetch_done, data_done, busy, timeout_err;

    int n_pass  = 0;
    int n_total = 0;
    bit started = 0;

    mem_access_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .RESET(RESET), .fetch_req(fetch_req), .data_req(data_req),
        .data_write(data_write), .data_size(data_size), .data_signed(data_signed),
        .MFC(MFC), .MAR_Enable(MAR_Enable), .MDR_Enable(MDR_Enable),
        .MDR_Mux_select(MDR_Mux_select), .RAM_enable(RAM_enable),
        .RAM_OpCode(RAM_OpCode), .IR_Enable(IR_Enable), .fetch_done(fetch_done),
        .data_done(data_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    wire [14:0] dut_vec = {MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
                           IR_Enable, fetch_done, data_done, busy, timeout_err};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: an access is a timeline counted from its acceptance edge.
    // t=1 is the address cycle, t>=2 waits for MFC, the cycle after MFC is
    // sampled captures, and TIMEOUT waits without MFC end in a sticky error.
    bit         m_act = 0, m_err = 0, m_fetch = 0, m_write = 0, m_last_data = 0, m_gd;
    logic [5:0] m_op = '0;
    int         m_t = 0, m_cap_t = 0;

    function automatic logic [14:0] model_vec();
        bit addr, wt, cap;
        addr = m_act && m_t == 1;
        wt   = m_act && m_t >= 2 && m_cap_t == 0;
        cap  = m_act && m_cap_t != 0;
        return {addr,
                (addr && !m_fetch && m_write) || (cap && !m_fetch && !m_write),
                cap && !m_fetch && !m_write,
                wt,
                wt ? m_op : 6'b000000,
                cap && m_fetch,
                cap && m_fetch,
                cap && !m_fetch,
                m_act || m_err,
                m_err};
    endfunction

    always @(posedge Clk) begin
        if (RESET) begin
            m_act = 0; m_err = 0; m_last_data = 0; m_t = 0; m_cap_t = 0;
        end else if (m_err) begin
            m_t = 0;
        end else if (!m_act) begin
            if (fetch_req || data_req) begin
                m_gd        = data_req && (!fetch_req || !m_last_data);
                m_last_data = m_gd;
                m_fetch     = !m_gd;
                m_write     = data_write;
                m_op        = m_gd ? {2'b00, data_signed, data_write, data_size} : 6'b000010;
                m_act = 1; m_t = 1; m_cap_t = 0;
            end
        end else if (m_cap_t != 0) begin
            m_act = 0;
        end else if (m_t == 1) begin
            m_t = 2;
        end else if (MFC) begin
            m_t++; m_cap_t = m_t;
        end else if (m_t - 1 == TIMEOUT) begin
            m_act = 0; m_err = 1;
        end else begin
            m_t++;
        end
        #1;
        if (started) check("cycle_outputs", 32'(dut_vec), 32'(model_vec()));
    end

    typedef struct {
        int mar, ram, ir, both, fd, dd, lat;
        logic [5:0] op;
        bit mdr_store, mdr_load;
    } res_t;

    // Runs one access from the current negedge; MFC rises on the mfc_at-th RAM cycle.
    task automatic do_access(input int mfc_at, input bit drop, input bit perturb, output res_t r);
        bit fin;
        r = '{default: 0};
        fin = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge Clk);
            if (MAR_Enable) begin
                r.mar++;
                if (MDR_Enable && !MDR_Mux_select) r.mdr_store = 1;
            end
            if (MDR_Enable && MDR_Mux_select) r.mdr_load = 1;
            if (RAM_enable) begin
                r.ram++;
                r.op = RAM_OpCode;
            end
            MFC = RAM_enable && (r.ram == mfc_at);
            if (IR_Enable) r.ir++;
            if (IR_Enable && fetch_done) r.both++;
            if (fetch_done) r.fd++;
            if (data_done) r.dd++;
            if (perturb && c == 0) begin
                data_write = ~data_write; data_size = ~data_size;
                data_signed = ~data_signed; data_req = 0;
            end
            if (fetch_done || data_done) begin
                r.lat = c; fin = 1; MFC = 0;
                if (drop) begin fetch_req = 0; data_req = 0; end
            end
        end
        if (!fin) begin
            n_total++;
            $display("FAIL access_budget: got no done pulse in 60 cycles, required one");
        end
    endtask

    res_t r;
    int   n;

    initial begin
        RESET = 1; fetch_req = 0; data_req = 0; data_write = 0;
        data_size = 2'b00; data_signed = 0; MFC = 0;
        repeat (2) @(negedge Clk);
        RESET = 0; started = 1;
        @(negedge Clk);
        check("reset_outputs", 32'(dut_vec), 0);

        // Fetch with MFC on the third RAM cycle.
        fetch_req = 1;
        do_access(3, 1, 0, r);
        check("fetch_mar_cycles", r.mar, 1);
        check("fetch_ram_cycles", r.ram, 3);
        check("fetch_opcode", r.op, 6'b000010);
        check("fetch_ir_cycles", r.ir, 1);
        check("fetch_ir_with_done", r.both, 1);
        check("fetch_latency", r.lat, 4);
        @(negedge Clk);
        check("idle_after_fetch", busy, 0);

        // Store word, MFC immediate: minimum latency.
        data_req = 1; data_write = 1; data_size = 2'b10; data_signed = 0;
        do_access(1, 1, 0, r);
        check("store_mar_mdr_mux0", r.mdr_store, 1);
        check("store_opcode", r.op, 6'b000110);
        check("store_latency", r.lat, 2);
        check("store_no_ir", r.ir, 0);
        check("store_no_mdr_capture", r.mdr_load, 0);
        check("store_data_done", r.dd, 1);

        // Round-robin tie after reset: data, fetch, data.
        @(negedge Clk);
        RESET = 1; data_write = 0;
        @(negedge Clk);
        RESET = 0; fetch_req = 1; data_req = 1;
        do_access(1, 0, 0, r);
        check("rr1_data", {r.dd[3:0], r.fd[3:0]}, 8'h10);
        do_access(1, 0, 0, r);
        check("rr2_fetch", {r.dd[3:0], r.fd[3:0]}, 8'h01);
        do_access(1, 1, 0, r);
        check("rr3_data", {r.dd[3:0], r.fd[3:0]}, 8'h10);

        // MFC never arrives: error after TIMEOUT waits, sticky until reset.
        @(negedge Clk);
        fetch_req = 1;
        n = 0;
        for (int c = 0; c < 40 && !timeout_err; c++) begin
            @(negedge Clk);
            if (RAM_enable) n++;
        end
        check("timeout_wait_cycles", n, 16);
        check("timeout_flag", timeout_err, 1);
        data_req = 1;
        repeat (5) @(negedge Clk);
        check("error_sticky_quiet", {timeout_err, MAR_Enable, RAM_enable, fetch_done, data_done}, 5'b10000);
        RESET = 1; fetch_req = 0; data_req = 0;
        @(negedge Clk);
        RESET = 0;
        check("reset_clears_error", {timeout_err, busy}, 2'b00);

        // Reset during WAIT_MFC with MFC on the same edge.
        fetch_req = 1;
        n = 0;
        for (int c = 0; c < 10 && !RAM_enable; c++) begin
            @(negedge Clk);
            n++;
        end
        check("reached_wait", RAM_enable, 1);
        RESET = 1; MFC = 1;
        @(negedge Clk);
        check("reset_wins_over_mfc", {busy, IR_Enable, MDR_Enable, fetch_done, data_done}, 5'b00000);
        RESET = 0; MFC = 0; fetch_req = 0;
        @(negedge Clk);
        check("no_late_done", {IR_Enable, fetch_done, data_done}, 3'b000);

        // Signed halfword load; inputs disturbed after acceptance.
        data_req = 1; data_write = 0; data_size = 2'b01; data_signed = 1;
        do_access(2, 1, 1, r);
        check("load_opcode", r.op, 6'b001001);
        check("load_mdr_from_ram", r.mdr_load, 1);
        check("load_no_store_path", r.mdr_store, 0);
        check("load_data_done", r.dd, 1);
        check("load_latency", r.lat, 3);

        repeat (2) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
